iir_sched: RTL and testbench

Sample scheduler that shares one first-order IIR compute unit between the low-pass and high-pass channels. On each sample tick it reads the next input sample from the sample ROM and runs the compute unit twice, once per channel, supplying that channel's coefficients and history. It then commits both channel outputs together, so the PWM stages always see a coherent pair. It sits between the ROM, the shared filter datapath and the two PWM generators.

---
 rtl/iir_sched.sv | 188 ++++++++++++++++++
 tb/tb_iir_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sched.sv
// Sequences one shared first-order IIR unit over the low-pass and high-pass channels per sample tick.
// Latency: tick in cycle 0 -> LP start in cycle 3, HP start in 4+D, outputs and out_valid in 6+2D.
// Backpressure: none; a tick while busy is dropped and latched in the sticky overrun flag.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-low reset
//   en, tick          scheduler enable and one-cycle sample request
//   rom_addr, rom_q   sample ROM address (registered) and data (2-cycle read)
//   filt_*            operand/coefficient buses, start/select, result and done strobe of the shared unit
//   low_pass,
//   high_pass         committed channel outputs, updated together
//   out_valid         one-cycle pulse when a new output pair is committed
//   busy, overrun     scheduler active, and sticky dropped-tick flag
module iir_sched #(
    parameter logic [31:0] LP_A1 = 32'h8000FC02,
    parameter logic [31:0] LP_B0 = 32'h000001FE,
    parameter logic [31:0] LP_B1 = 32'h000001FE,
    parameter logic [31:0] HP_A1 = 32'h8000DAA5,
    parameter logic [31:0] HP_B0 = 32'h0000ED52,
    parameter logic [31:0] HP_B1 = 32'h8000ED52
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tick,
    output logic [14:0] rom_addr,
    input  logic [22:0] rom_q,
    output logic        filt_start,
    output logic        filt_sel,
    output logic [31:0] filt_x,
    output logic [31:0] filt_xp,
    output logic [31:0] filt_yp,
    output logic [31:0] filt_a1,
    output logic [31:0] filt_b0,
    output logic [31:0] filt_b1,
    input  logic [31:0] filt_y,
    input  logic        filt_done,
    output logic [31:0] low_pass,
    output logic [31:0] high_pass,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_LP_START = 3'd3,
        S_LP_WAIT  = 3'd4,
        S_HP_START = 3'd5,
        S_HP_WAIT  = 3'd6,
        S_COMMIT   = 3'd7
    } state_t;

    state_t      state;

    // Per-sample working registers. y_lp / y_hp are the committed filter
    // history; the *_new copies hold results until both channels are done so
    // the history and the outputs always move as a coherent pair.
    logic [31:0] x_cur;
    logic [31:0] x_prev;
    logic [31:0] y_lp;
    logic [31:0] y_hp;
    logic [31:0] y_lp_new;
    logic [31:0] y_hp_new;

    logic        tick_acc;

    assign tick_acc = tick & en;

    // Operand buses are pure muxes of registers that only change in LATCH and
    // COMMIT, and filt_sel only changes when a start is issued, so every bus
    // is stable from the start pulse through the matching done strobe.
    always_comb begin
        filt_x  = x_cur;
        filt_xp = x_prev;
        if (filt_sel) begin
            filt_yp = y_hp;
            filt_a1 = HP_A1;
            filt_b0 = HP_B0;
            filt_b1 = HP_B1;
        end else begin
            filt_yp = y_lp;
            filt_a1 = LP_A1;
            filt_b0 = LP_B0;
            filt_b1 = LP_B1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            x_cur      <= '0;
            x_prev     <= '0;
            y_lp       <= '0;
            y_hp       <= '0;
            y_lp_new   <= '0;
            y_hp_new   <= '0;
            low_pass   <= '0;
            high_pass  <= '0;
            filt_start <= 1'b0;
            filt_sel   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            filt_start <= 1'b0;
            out_valid  <= 1'b0;

            // Any enabled tick outside IDLE is dropped; remember that it happened.
            if (tick_acc && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick_acc) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end

                // rom_addr has been stable since the previous commit, so the
                // ROM data is valid by the time LATCH samples it.
                S_FETCH: begin
                    state <= S_LATCH;
                end

                // Start pulse and channel select are issued here so that they
                // are registered outputs during LP_START itself.
                S_LATCH: begin
                    x_cur      <= {9'b0, rom_q};
                    filt_sel   <= 1'b0;
                    filt_start <= 1'b1;
                    state      <= S_LP_START;
                end

                // A done strobe coinciding with the start pulse is not a real
                // result, so START states never look at filt_done.
                S_LP_START: begin
                    state <= S_LP_WAIT;
                end

                S_LP_WAIT: begin
                    if (filt_done) begin
                        y_lp_new   <= filt_y;
                        filt_sel   <= 1'b1;
                        filt_start <= 1'b1;
                        state      <= S_HP_START;
                    end
                end

                S_HP_START: begin
                    state <= S_HP_WAIT;
                end

                S_HP_WAIT: begin
                    if (filt_done) begin
                        y_hp_new <= filt_y;
                        state    <= S_COMMIT;
                    end
                end

                S_COMMIT: begin
                    low_pass  <= y_lp_new;
                    high_pass <= y_hp_new;
                    y_lp      <= y_lp_new;
                    y_hp      <= y_hp_new;
                    x_prev    <= x_cur;
                    rom_addr  <= rom_addr + 15'd1;   // wraps 32767 -> 0 naturally
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    filt_sel  <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_sched.sv
module tb_iir_sched;

    localparam logic [31:0] LP_A1 = 32'h8000FC02;
    localparam logic [31:0] LP_B0 = 32'h000001FE;
    localparam logic [31:0] LP_B1 = 32'h000001FE;
    localparam logic [31:0] HP_A1 = 32'h8000DAA5;
    localparam logic [31:0] HP_B0 = 32'h0000ED52;
    localparam logic [31:0] HP_B1 = 32'h8000ED52;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        tick = 1'b0;
    logic [14:0] rom_addr;
    logic [22:0] rom_q = '0;
    logic [22:0] rom_q1 = '0;
    logic        filt_start, filt_sel;
    logic [31:0] filt_x, filt_xp, filt_yp, filt_a1, filt_b0, filt_b1;
    logic [31:0] filt_y = '0;
    logic        filt_done = 1'b0;
    logic [31:0] low_pass, high_pass;
    logic        out_valid, busy, overrun;

    always #5 clk = ~clk;

    iir_sched dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .filt_start(filt_start), .filt_sel(filt_sel),
        .filt_x(filt_x), .filt_xp(filt_xp), .filt_yp(filt_yp),
        .filt_a1(filt_a1), .filt_b0(filt_b0), .filt_b1(filt_b1),
        .filt_y(filt_y), .filt_done(filt_done),
        .low_pass(low_pass), .high_pass(high_pass),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit checking = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bench ROM contents: fixed values at 0/1, hashed elsewhere; 2-cycle read.
    function automatic logic [22:0] rom_fn(input logic [14:0] a);
        logic [31:0] h;
        if (a == 15'd0) return 23'd100;
        if (a == 15'd1) return 23'd200;
        h = 32'(a) * 32'h9E3779B1;
        return h[27:5];
    endfunction

    always @(posedge clk) begin
        rom_q1 <= rom_fn(rom_addr);
        rom_q  <= rom_q1;
    end

    // Driver-chosen per-sample settings, latched by the model at acceptance.
    int          dly = 2;
    logic [31:0] ret_lp = '0, ret_hp = '0;
    bit          spur_en = 0;

    // Behavioural model: one sample in flight described by its accept cycle.
    bit          m_act = 0;
    int          t0 = 0, md = 1;
    logic [31:0] m_x = '0, m_xprev = '0, m_ylp = '0, m_yhp = '0;
    logic [31:0] m_low = '0, m_high = '0, m_rlp = '0, m_rhp = '0;
    logic [14:0] m_addr = '0;
    bit          m_ovr = 0;

    // Observations used by the literal expectations.
    int          lp_st_cyc = 0, hp_st_cyc = 0, ov_cyc = 0;
    logic [31:0] lp_x_s = '0, lp_xp_s = '0, lp_yp_s = '0, hp_x_s = '0, hp_yp_s = '0;
    logic [31:0] lp_a1_s = '0, lp_b0_s = '0, hp_a1_s = '0, hp_b1_s = '0;

    // Compute-unit responder.
    int          done_cyc = -1;
    logic [31:0] done_y = '0;

    always @(posedge clk) begin
        bit in_win;
        cyc = cyc + 1;
        #1;
        in_win = m_act && (((cyc > t0 + 3) && (cyc <= t0 + 3 + md)) ||
                           ((cyc > t0 + 4 + md) && (cyc <= t0 + 4 + 2 * md)));
        if (cyc == done_cyc) begin
            filt_done = 1'b1;
            filt_y    = done_y;
        end else if (spur_en && !in_win && ($urandom % 5 == 0)) begin
            filt_done = 1'b1;
            filt_y    = 32'hDEADBEEF;
        end else begin
            filt_done = 1'b0;
            filt_y    = 32'h0;
        end
    end

    // Compare process: checks every cycle, then advances the model with this cycle's inputs.
    always @(negedge clk) begin
        bit exp_ov, exp_st;
        if (checking) begin
            exp_ov = 0;
            if (m_act && (cyc == t0 + 6 + 2 * md)) begin
                m_act   = 0;
                exp_ov  = 1;
                m_low   = m_rlp;
                m_high  = m_rhp;
                m_ylp   = m_rlp;
                m_yhp   = m_rhp;
                m_xprev = m_x;
                m_addr  = m_addr + 15'd1;
            end
            exp_st = m_act && ((cyc == t0 + 3) || (cyc == t0 + 4 + md));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("filt_start", 32'(filt_start), 32'(exp_st));
            chk("busy", 32'(busy), 32'(m_act));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("low_pass", low_pass, m_low);
            chk("high_pass", high_pass, m_high);
            chk("rom_addr", 32'(rom_addr), 32'(m_addr));
            if (m_act && (cyc == t0 + 3)) begin
                chk("lp_sel", 32'(filt_sel), 32'd0);
                chk("lp_x", filt_x, m_x);
                chk("lp_xp", filt_xp, m_xprev);
                chk("lp_yp", filt_yp, m_ylp);
                chk("lp_a1", filt_a1, LP_A1);
                chk("lp_b0", filt_b0, LP_B0);
                chk("lp_b1", filt_b1, LP_B1);
            end
            if (m_act && (cyc == t0 + 4 + md)) begin
                chk("hp_sel", 32'(filt_sel), 32'd1);
                chk("hp_x", filt_x, m_x);
                chk("hp_xp", filt_xp, m_xprev);
                chk("hp_yp", filt_yp, m_yhp);
                chk("hp_a1", filt_a1, HP_A1);
                chk("hp_b0", filt_b0, HP_B0);
                chk("hp_b1", filt_b1, HP_B1);
            end
            if (out_valid) ov_cyc = cyc;
            if (filt_start) begin
                done_cyc = cyc + md;
                done_y   = filt_sel ? m_rhp : m_rlp;
                if (!filt_sel) begin
                    lp_st_cyc = cyc; lp_x_s = filt_x; lp_xp_s = filt_xp; lp_yp_s = filt_yp;
                    lp_a1_s = filt_a1; lp_b0_s = filt_b0;
                end else begin
                    hp_st_cyc = cyc; hp_x_s = filt_x; hp_yp_s = filt_yp;
                    hp_a1_s = filt_a1; hp_b1_s = filt_b1;
                end
            end
            if (!rst) begin
                m_act = 0; m_ovr = 0; m_x = '0; m_xprev = '0; m_ylp = '0; m_yhp = '0;
                m_low = '0; m_high = '0; m_addr = '0;
            end else if (tick && en) begin
                if (m_act) begin
                    m_ovr = 1;
                end else begin
                    m_act = 1; t0 = cyc; md = dly;
                    m_x   = {9'b0, rom_fn(m_addr)};
                    m_rlp = ret_lp; m_rhp = ret_hp;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sample(input int d, input logic [31:0] rl, input logic [31:0] rh, output int t);
        dly = d; ret_lp = rl; ret_hp = rh;
        en = 1; tick = 1; t = cyc;
        step();
        tick = 0;
        repeat (6 + 2 * d) step();
    endtask

    initial begin
        int t;
        repeat (3) step();
        checking = 1;
        step();
        rst = 1;
        step();
        chk("rst_low_pass", low_pass, 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // First sample: ROM[0]=100, LP=50, HP=7, D=2.
        run_sample(2, 32'd50, 32'd7, t);
        chk("s1_lp_start_cyc", 32'(lp_st_cyc - t), 32'd3);
        chk("s1_hp_start_cyc", 32'(hp_st_cyc - t), 32'd6);
        chk("s1_out_valid_cyc", 32'(ov_cyc - t), 32'd10);
        chk("s1_lp_x", lp_x_s, 32'd100);
        chk("s1_lp_xp", lp_xp_s, 32'd0);
        chk("s1_lp_yp", lp_yp_s, 32'd0);
        chk("s1_low_pass", low_pass, 32'd50);
        chk("s1_high_pass", high_pass, 32'd7);
        chk("s1_rom_addr", 32'(rom_addr), 32'd1);

        // Second sample: ROM[1]=200, history from the first.
        run_sample(2, 32'd11, 32'd22, t);
        chk("s2_lp_xp", lp_xp_s, 32'd100);
        chk("s2_lp_yp", lp_yp_s, 32'd50);
        chk("s2_hp_yp", hp_yp_s, 32'd7);
        chk("s2_hp_x", hp_x_s, 32'd200);
        chk("s2_lp_a1", lp_a1_s, 32'h8000FC02);
        chk("s2_lp_b0", lp_b0_s, 32'h000001FE);
        chk("s2_hp_a1", hp_a1_s, 32'h8000DAA5);
        chk("s2_hp_b1", hp_b1_s, 32'h8000ED52);

        // Tick in cycle 4 of a sample.
        dly = 2; ret_lp = 32'd5; ret_hp = 32'd6;
        tick = 1; t = cyc;
        step(); tick = 0;
        repeat (3) step();
        tick = 1;
        step(); tick = 0;
        chk("ovr_cycle5", 32'(overrun), 32'd1);
        repeat (8) step();
        chk("ovr_low_pass", low_pass, 32'd5);
        chk("ovr_rom_addr", 32'(rom_addr), 32'd3);

        // Reset during HP_WAIT (D=3: HP_WAIT from cycle 8), done arrives after.
        dly = 3; ret_lp = 32'd9; ret_hp = 32'd10;
        tick = 1; t = cyc;
        step(); tick = 0;
        repeat (7) step();
        rst = 0;
        step();
        rst = 1;
        repeat (6) step();
        chk("rstmid_low_pass", low_pass, 32'd0);
        chk("rstmid_high_pass", high_pass, 32'd0);
        chk("rstmid_rom_addr", 32'(rom_addr), 32'd0);
        chk("rstmid_overrun", 32'(overrun), 32'd0);
        run_sample(1, 32'd3, 32'd4, t);
        chk("rstmid_lp_start_cyc", 32'(lp_st_cyc - t), 32'd3);
        chk("rstmid_out_valid_cyc", 32'(ov_cyc - t), 32'd8);
        chk("rstmid_low_pass2", low_pass, 32'd3);

        // en low: ticks ignored entirely.
        en = 0;
        for (int i = 0; i < 20; i++) begin
            tick = (i % 2 == 0);
            step();
        end
        tick = 0;
        chk("en0_busy", 32'(busy), 32'd0);
        chk("en0_overrun", 32'(overrun), 32'd0);
        chk("en0_rom_addr", 32'(rom_addr), 32'd1);

        // Address wrap: preload 32767, run one sample.
        checking = 0;
        force dut.rom_addr = 15'h7FFF;
        step();
        release dut.rom_addr;
        m_addr = 15'h7FFF;
        repeat (3) step();
        checking = 1;
        run_sample(1, 32'd77, 32'd88, t);
        chk("wrap_rom_addr", 32'(rom_addr), 32'd0);
        chk("wrap_low_pass", low_pass, 32'd77);

        // Randomized traffic with enable drops and spurious done strobes.
        spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            en     = ($urandom % 10) != 0;
            tick   = ($urandom % 7) == 0;
            dly    = $urandom_range(1, 4);
            ret_lp = $urandom;
            ret_hp = $urandom;
            step();
        end
        en = 0; tick = 0; spur_en = 0;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
